// File: rtl/vga_rect_fill.sv
// vga_rect_fill
// -------------
// Solid-rectangle fill engine feeding a 640x480 RGB444 framebuffer.
// A command (x, y, w, h, colour) is accepted over a valid/ready handshake,
// clipped to the visible area, and then written out as one framebuffer
// write per clock in raster order (left-to-right, top-to-bottom).
//
// Ports:
//   clk        pixel/system clock, shared with the framebuffer
//   rst        asynchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  engine can accept a command (high only while idle)
//   cmd_x      left column of the rectangle
//   cmd_y      top row of the rectangle
//   cmd_w      width in pixels
//   cmd_h      height in lines
//   cmd_color  fill colour, {r,g,b} nibbles
//   busy       command being set up or filled
//   done       one-cycle pulse when a command completes
//   fb_we      framebuffer write enable
//   fb_addr    framebuffer write address (row-major, pitch H_VISIBLE)
//   fb_data    framebuffer write data
module vga_rect_fill #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [11:0] cmd_color,
    output logic        busy,
    output logic        done,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [11:0] fb_data
);

    localparam logic [10:0] H_LIM   = 11'(H_VISIBLE);
    localparam logic [10:0] V_LIM   = 11'(V_VISIBLE);
    localparam logic [18:0] H_PITCH = 19'(H_VISIBLE);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Latched command and clipped extents
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [11:0] color_q;
    logic [10:0] cw_q;
    logic [10:0] ch_q;

    // Fill position counters and the address of the current row's column 0
    logic [9:0]  col;
    logic [9:0]  row;
    logic [18:0] row_base;

    logic        accept;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] w_ext;
    logic [10:0] h_ext;
    logic [10:0] h_room;
    logic [10:0] v_room;
    logic [10:0] cw_clip;
    logic [10:0] ch_clip;
    logic        empty;
    logic        last_col;
    logic        last_row;
    logic [18:0] x_off;
    logic [18:0] row_start;
    logic [18:0] next_row_base;

    assign accept = cmd_valid && (state == IDLE);

    // Clipping in 11 bits so that 640-x and the comparisons never wrap.
    // A rectangle starting off-screen collapses to zero size; otherwise the
    // extent is limited to the room left before the right/bottom edge.
    assign x_ext  = {1'b0, cmd_x};
    assign y_ext  = {1'b0, cmd_y};
    assign w_ext  = {1'b0, cmd_w};
    assign h_ext  = {1'b0, cmd_h};
    assign h_room = H_LIM - x_ext;
    assign v_room = V_LIM - y_ext;

    always_comb begin
        cw_clip = 11'd0;
        ch_clip = 11'd0;
        if (x_ext < H_LIM) begin
            cw_clip = (w_ext < h_room) ? w_ext : h_room;
        end
        if (y_ext < V_LIM) begin
            ch_clip = (h_ext < v_room) ? h_ext : v_room;
        end
    end

    assign empty    = (cw_q == 11'd0) || (ch_q == 11'd0);
    assign last_col = ({1'b0, col} == (cw_q - 11'd1));
    assign last_row = ({1'b0, row} == (ch_q - 11'd1));

    // The only multiply: start-of-row address for the first line, used in
    // SETUP. Every later address is produced by incrementing.
    assign x_off         = {9'd0, x_q};
    assign row_start     = 19'(y_q) * H_PITCH;
    assign next_row_base = row_base + H_PITCH;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; SETUP and DONE each last exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = empty ? DONE : FILL;
            end
            FILL: begin
                if (last_col && last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs are straight decodes of the state register
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SETUP) || (state == FILL);
    assign done      = (state == DONE);

    // Command latch. The clipped extents are captured at accept so the
    // fill loop only ever compares against small registered values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            color_q <= 12'd0;
            cw_q    <= 11'd0;
            ch_q    <= 11'd0;
        end else if (accept) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            color_q <= cmd_color;
            cw_q    <= cw_clip;
            ch_q    <= ch_clip;
        end
    end

    // Fill datapath. The framebuffer outputs are registered; the first
    // write is loaded on the SETUP edge so it appears in the first FILL
    // cycle. Within a row the address simply increments; at the end of a
    // row it jumps to the next row base plus x. fb_addr/fb_data are left
    // untouched whenever no write is issued, so they hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= 10'd0;
            row      <= 10'd0;
            row_base <= 19'd0;
            fb_we    <= 1'b0;
            fb_addr  <= 19'd0;
            fb_data  <= 12'd0;
        end else begin
            case (state)
                SETUP: begin
                    col      <= 10'd0;
                    row      <= 10'd0;
                    row_base <= row_start;
                    if (!empty) begin
                        fb_we   <= 1'b1;
                        fb_addr <= row_start + x_off;
                        fb_data <= color_q;
                    end
                end
                FILL: begin
                    if (last_col) begin
                        col <= 10'd0;
                        if (last_row) begin
                            fb_we <= 1'b0;
                        end else begin
                            row      <= row + 10'd1;
                            row_base <= next_row_base;
                            fb_addr  <= next_row_base + x_off;
                        end
                    end else begin
                        col     <= col + 10'd1;
                        fb_addr <= fb_addr + 19'd1;
                    end
                end
                default: begin
                    fb_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill
// ----------------
// Bench for vga_rect_fill. Each command's expected write list is built
// from the clipping rule with plain arithmetic and compared with the
// writes seen on the framebuffer port, together with handshake timing.
module tb_vga_rect_fill;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [9:0]  cmd_h;
    logic [11:0] cmd_color;
    logic        busy;
    logic        done;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;

    int errors;
    int checks;

    vga_rect_fill dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data)
    );

    // 100 MHz simulation clock; only relative cycle timing matters
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the stimulus
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one command, then watch the port until done. The caller is
    // positioned just after a clock edge with the engine idle. With hold
    // set, cmd_valid stays high after acceptance and the next command's
    // fields are presented immediately, so it is taken on the first idle edge.
    task automatic applyStimulus(
        input logic [9:0]  x,
        input logic [9:0]  y,
        input logic [9:0]  w,
        input logic [9:0]  h,
        input logic [11:0] color,
        input bit          hold,
        input logic [9:0]  nx,
        input logic [9:0]  ny,
        input logic [9:0]  nw,
        input logic [9:0]  nh,
        input logic [11:0] ncolor
    );
        int exp_addr[$];
        int got_addr[$];
        int got_data[$];
        int got_k[$];
        int cwm;
        int chm;
        int n;
        int done_k;
        int ready_hi;

        // Reference: clip to the visible area, list the addresses in raster order
        cwm = (int'(x) >= 640) ? 0 : ((int'(w) < 640 - int'(x)) ? int'(w) : 640 - int'(x));
        chm = (int'(y) >= 480) ? 0 : ((int'(h) < 480 - int'(y)) ? int'(h) : 480 - int'(y));
        for (int r = 0; r < chm; r++) begin
            for (int c = 0; c < cwm; c++) begin
                exp_addr.push_back((int'(y) + r) * 640 + int'(x) + c);
            end
        end
        n = cwm * chm;

        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_color = color;
        cmd_valid = 1'b1;
        checkOutput("ready_before_accept", int'(cmd_ready), 1);

        @(posedge clk);
        #1;
        if (hold) begin
            cmd_x     = nx;
            cmd_y     = ny;
            cmd_w     = nw;
            cmd_h     = nh;
            cmd_color = ncolor;
        end else begin
            cmd_valid = 1'b0;
        end

        // Sample 0: the SETUP cycle
        checkOutput("busy_setup", int'(busy), 1);
        checkOutput("we_setup", int'(fb_we), 0);
        ready_hi = int'(cmd_ready);

        done_k = -1;
        for (int k = 1; k <= n + 8; k++) begin
            @(posedge clk);
            #1;
            if (fb_we) begin
                got_addr.push_back(int'(fb_addr));
                got_data.push_back(int'(fb_data));
                got_k.push_back(k);
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (cmd_ready) ready_hi++;
        end

        checkOutput("done_latency", done_k, n + 1);
        checkOutput("write_count", got_addr.size(), n);
        checkOutput("ready_low_while_busy", ready_hi, 0);
        for (int i = 0; i < got_addr.size() && i < n; i++) begin
            checkOutput("write_addr", got_addr[i], exp_addr[i]);
            checkOutput("write_data", got_data[i], int'(color));
            checkOutput("write_cycle", got_k[i], i + 1);
        end
        if (done_k > 0) begin
            checkOutput("we_at_done", int'(fb_we), 0);
            checkOutput("busy_at_done", int'(busy), 0);
            if (n > 0) begin
                checkOutput("addr_hold_at_done", int'(fb_addr), exp_addr[n - 1]);
                checkOutput("data_hold_at_done", int'(fb_data), int'(color));
            end
        end

        @(posedge clk);
        #1;
        checkOutput("ready_after_done", int'(cmd_ready), 1);
        checkOutput("done_single_pulse", int'(done), 0);
    endtask

    initial begin
        logic [9:0]  rx;
        logic [9:0]  ry;
        logic [9:0]  rw;
        logic [9:0]  rh;
        logic [11:0] rc;
        int          dones;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;

        // Reset state
        #2;
        checkOutput("rst_ready", int'(cmd_ready), 1);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_we", int'(fb_we), 0);
        checkOutput("rst_addr", int'(fb_addr), 0);
        checkOutput("rst_data", int'(fb_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Small interior rectangle
        applyStimulus(10'd10, 10'd2, 10'd3, 10'd2, 12'h0A5, 1'b0, '0, '0, '0, '0, '0);
        // Bottom-right corner, clipped in both directions
        applyStimulus(10'd638, 10'd479, 10'd5, 10'd4, 12'h123, 1'b0, '0, '0, '0, '0, '0);
        // Zero width and off-screen start: no writes
        applyStimulus(10'd5, 10'd5, 10'd0, 10'd4, 12'h777, 1'b0, '0, '0, '0, '0, '0);
        applyStimulus(10'd700, 10'd3, 10'd4, 10'd4, 12'h777, 1'b0, '0, '0, '0, '0, '0);
        applyStimulus(10'd3, 10'd480, 10'd4, 10'd4, 12'h777, 1'b0, '0, '0, '0, '0, '0);
        // Exactly touching the right and bottom edges: no clipping
        applyStimulus(10'd630, 10'd477, 10'd10, 10'd3, 12'hABC, 1'b0, '0, '0, '0, '0, '0);
        applyStimulus(10'd0, 10'd478, 10'd640, 10'd2, 12'hF00, 1'b0, '0, '0, '0, '0, '0);
        // Oversized width: clipped with no wrap into the next line
        applyStimulus(10'd620, 10'd10, 10'd1023, 10'd2, 12'h0F0, 1'b0, '0, '0, '0, '0, '0);
        // Back-to-back with cmd_valid held across completion
        applyStimulus(10'd100, 10'd100, 10'd4, 10'd3, 12'h111, 1'b1,
                      10'd200, 10'd50, 10'd2, 10'd2, 12'h222);
        applyStimulus(10'd200, 10'd50, 10'd2, 10'd2, 12'h222, 1'b0, '0, '0, '0, '0, '0);

        // Randomized commands, biased toward the edges
        for (int i = 0; i < 30; i++) begin
            case ($urandom % 3)
                0:       rx = 10'($urandom_range(0, 639));
                1:       rx = 10'($urandom_range(600, 700));
                default: rx = 10'($urandom_range(0, 1023));
            endcase
            case ($urandom % 3)
                0:       ry = 10'($urandom_range(0, 479));
                1:       ry = 10'($urandom_range(460, 520));
                default: ry = 10'($urandom_range(0, 1023));
            endcase
            if ($urandom % 4 == 0) begin
                rw = 10'($urandom_range(0, 1023));
                rh = 10'($urandom_range(0, 3));
            end else begin
                rw = 10'($urandom_range(0, 40));
                rh = 10'($urandom_range(0, 20));
            end
            rc = 12'($urandom);
            applyStimulus(rx, ry, rw, rh, rc, 1'b0, '0, '0, '0, '0, '0);
        end

        // Reset in the middle of a 100x100 fill
        cmd_x     = 10'd50;
        cmd_y     = 10'd50;
        cmd_w     = 10'd100;
        cmd_h     = 10'd100;
        cmd_color = 12'h5A5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("we_before_reset", int'(fb_we), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midfill_rst_we", int'(fb_we), 0);
        checkOutput("midfill_rst_busy", int'(busy), 0);
        checkOutput("midfill_rst_ready", int'(cmd_ready), 1);
        dones = int'(done);
        repeat (3) begin
            @(posedge clk);
            #1;
            dones += int'(done);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            dones += int'(done);
        end
        checkOutput("midfill_no_done", dones, 0);
        checkOutput("midfill_idle_we", int'(fb_we), 0);

        // Engine runs normally after the reset
        applyStimulus(10'd20, 10'd30, 10'd5, 10'd3, 12'h9C3, 1'b0, '0, '0, '0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
